led_seq_ctrl: RTL and testbench
===============================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter NLED, default 10, number of LED outputs.
REQ-002 SHALL have parameter NSW, default 10, number of switch inputs.
REQ-003 SHALL have parameter DEB_CYCLES, default 500000, debounce stability window in clocks (10 ms at 50 MHz).
REQ-004 SHALL have port clk, input, 1, single system clock (50 MHz).
REQ-005 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port address, input, 2, Avalon-MM word address.
REQ-007 SHALL have port write, input, 1, Avalon-MM write strobe.
REQ-008 SHALL have port writedata, input, 32, Avalon-MM write data.
REQ-009 SHALL have port read, input, 1, Avalon-MM read strobe.
REQ-010 SHALL have port readdata, output, 32, Avalon-MM read data.
REQ-011 SHALL have port sw, input, NSW, raw asynchronous switch levels.
REQ-012 SHALL have port ledr, output, NLED, registered LED drive.

Function
REQ-013 SHALL decode the register map: 0 CTRL ([1:0] mode, [2] enable), 1 PATTERN ([NLED-1:0]), 2 PERIOD ([23:0] clocks per tick), 3 SWSTAT (read-only debounced switches).
REQ-014 SHALL support mode values 0 DIRECT, 1 BLINK and 2 CHASE, and SHALL treat mode 3 as DIRECT.
REQ-015 SHALL implement reads with a fixed latency of 1 clock, no waitrequest, and zero-filled unused bits; a read of SWSTAT SHALL return the debounced value.
REQ-016 SHALL ignore writes to SWSTAT.
REQ-017 SHALL return the pre-write value when a read and a write to the same address occur in the same cycle.
REQ-018 SHALL provide a tick counter that counts 0..PERIOD-1 and pulses tick for one cycle when it reaches PERIOD-1, then wraps to 0; PERIOD=0 SHALL behave as PERIOD=1, giving a tick every cycle.
REQ-019 SHALL clear the tick counter and the sequence phase on any write to CTRL or PERIOD, effective the cycle after the write.
REQ-020 SHALL implement the sequencer FSM with states OFF, DIRECT, BLINK_ON, BLINK_OFF and CHASE, where enable=0 forces OFF.
REQ-021 SHALL drive ledr=0 in OFF and hold the counter at 0.
REQ-022 SHALL drive ledr=PATTERN in DIRECT and SHALL track PATTERN writes one cycle after the write.
REQ-023 SHALL enter BLINK_ON (ledr=PATTERN) when BLINK is selected and SHALL alternate between BLINK_ON and BLINK_OFF (ledr=0) on each tick.
REQ-024 SHALL make CHASE drive a one-hot value starting at bit 0, shift left on each tick and wrap from bit NLED-1 to bit 0, ignoring PATTERN.
REQ-025 SHALL resolve the state from the new CTRL value on the cycle after a CTRL write, regardless of the current state.

Debounce
REQ-026 SHALL pass each sw bit through a 2-flop synchronizer.
REQ-027 SHALL update a debounced bit only after its synchronized value differs from the debounced value for DEB_CYCLES consecutive clocks; any reversion SHALL restart that bit's count.

Reset
REQ-028 SHALL, with reset_n low, asynchronously force ledr=0, readdata=0, CTRL=0, PATTERN=0, PERIOD=25000000, the tick counter to 0, the FSM to OFF, debounced switches to 0, the synchronizers to 0 and the debounce counters to 0.
REQ-029 SHALL abort any in-progress tick or debounce count when reset is asserted mid-operation, and SHALL start the next count from 0 after reset deassertion.

Structure
REQ-030 SHALL place the register address constants, the mode enum and the FSM state typedef in package led_seq_pkg.
REQ-031 SHALL instantiate sub-module sw_debounce (parameter DEB_CYCLES, one instance per switch bit, or vectorised over NSW).
REQ-032 SHALL be fully synchronous to clk, with no gated clocks or latches.

Verification (bench parameters: DEB_CYCLES=8, NLED=10)
REQ-033 SHALL verify DIRECT: write PATTERN=0x2A5, then write CTRL=0x4 -> ledr=0x2A5 on the cycle after the CTRL write, and a subsequent read of address 1 returns 0x2A5 one cycle after read.
REQ-034 SHALL verify BLINK: write PERIOD=4, PATTERN=0x3FF, CTRL=0x5 -> ledr alternates between 0x3FF and 0x000 every 4 clocks, starting with 0x3FF.
REQ-035 SHALL verify CHASE wrap: write PERIOD=1, CTRL=0x6 -> ledr follows 0x001, 0x002 … 0x200, then 0x001, changing on every clock.
REQ-036 SHALL verify debounce: hold sw[0]=1 for 7 clocks, then 0, then 1 for 10 clocks -> SWSTAT[0]=0 through the glitch, and SWSTAT[0]=1 only after the 8th stable synchronized clock.
REQ-037 SHALL verify reset mid-operation: in CHASE with ledr=0x010, pulse reset_n low -> ledr=0 immediately and CTRL reads 0 after release.
REQ-038 SHALL verify PERIOD=0: with CTRL=0x5 and PERIOD=0 -> ledr toggles on every clock.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared constants and types for the LED sequencer: register map, modes, FSM states.
package led_seq_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PATTERN = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_SWSTAT  = 2'd3;

  // PERIOD is written through a 24-bit field, but its reset value (0.5 s at
  // 50 MHz) needs 25 bits, so the register itself is one bit wider.
  localparam int unsigned PERIOD_W     = 25;
  localparam logic [PERIOD_W-1:0] PERIOD_RESET = 25'd25000000;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_DIRECT    = 3'd1,
    ST_BLINK_ON  = 3'd2,
    ST_BLINK_OFF = 3'd3,
    ST_CHASE     = 3'd4
  } state_t;

  // Entry state selected by a CTRL value ([2] enable, [1:0] mode).
  function automatic state_t resolve_state(input logic [2:0] ctrl);
    state_t st;
    if (!ctrl[2]) begin
      st = ST_OFF;
    end else begin
      case (mode_t'(ctrl[1:0]))
        MODE_BLINK: st = ST_BLINK_ON;
        MODE_CHASE: st = ST_CHASE;
        default:    st = ST_DIRECT;
      endcase
    end
    return st;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_sw_debounce.sv
// One switch bit: 2-flop synchronizer followed by a stability-window debouncer.
module sw_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_i,
  output logic deb_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          meta_q;
  logic          sync_q;
  logic          deb_q;
  logic [CW-1:0] cnt_q;

  // Bring the raw level into the clock domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= sw_i;
      sync_q <= meta_q;
    end
  end

  // Accept a new level only after it has differed for DEB_CYCLES clocks in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else if (sync_q != deb_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_q <= sync_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// Avalon-MM LED sequencer: DIRECT / BLINK / CHASE modes plus debounced switch status.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int NLED       = 10,
  parameter int NSW        = 10,
  parameter int DEB_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      address,
  input  logic            write,
  input  logic [31:0]     writedata,
  input  logic            read,
  output logic [31:0]     readdata,
  input  logic [NSW-1:0]  sw,
  output logic [NLED-1:0] ledr
);

  logic [2:0]          ctrl_q, ctrl_d;
  logic [NLED-1:0]     pattern_q, pattern_d;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] last_cnt;
  logic [31:0]         readdata_q;
  logic [NLED-1:0]     ledr_q;
  logic [NSW-1:0]      sw_deb;
  state_t              state_q;
  state_t              entry_state;
  logic                restart;
  logic                tick;
  logic                unused_wdata;

  // Forwarded next values let the outputs follow a write in the same edge.
  assign ctrl_d      = (write && address == ADDR_CTRL) ? writedata[2:0] : ctrl_q;
  assign pattern_d   = (write && address == ADDR_PATTERN) ? writedata[NLED-1:0] : pattern_q;
  assign restart     = write && (address == ADDR_CTRL || address == ADDR_PERIOD);
  assign entry_state = resolve_state(ctrl_d);
  assign last_cnt    = (period_q == '0) ? '0 : period_q - 1'b1;
  assign tick        = (state_q != ST_OFF) && (cnt_q == last_cnt);
  assign unused_wdata = &{1'b0, writedata};

  // Writable registers; SWSTAT writes fall through and are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q    <= '0;
      pattern_q <= '0;
      period_q  <= PERIOD_RESET;
    end else if (write) begin
      case (address)
        ADDR_CTRL:    ctrl_q    <= writedata[2:0];
        ADDR_PATTERN: pattern_q <= writedata[NLED-1:0];
        ADDR_PERIOD:  period_q  <= {1'b0, writedata[23:0]};
        default:      ;
      endcase
    end
  end

  // Registered read port: samples pre-write register values, zero-extended.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else if (read) begin
      case (address)
        ADDR_CTRL:    readdata_q <= {29'd0, ctrl_q};
        ADDR_PATTERN: readdata_q <= 32'(pattern_q);
        ADDR_PERIOD:  readdata_q <= 32'(period_q);
        default:      readdata_q <= 32'(sw_deb);
      endcase
    end
  end

  // Tick prescaler; a CTRL/PERIOD write restarts the phase from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (restart || state_q == ST_OFF || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Sequencer FSM with registered LED drive; CHASE uses ledr_q as its one-hot position.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_OFF;
      ledr_q  <= '0;
    end else if (restart) begin
      state_q <= entry_state;
      case (entry_state)
        ST_DIRECT, ST_BLINK_ON: ledr_q <= pattern_d;
        ST_CHASE:               ledr_q <= NLED'(1);
        default:                ledr_q <= '0;
      endcase
    end else begin
      case (state_q)
        ST_OFF: ledr_q <= '0;
        ST_DIRECT: ledr_q <= pattern_d;
        ST_BLINK_ON: begin
          if (tick) begin
            state_q <= ST_BLINK_OFF;
            ledr_q  <= '0;
          end else begin
            ledr_q  <= pattern_d;
          end
        end
        ST_BLINK_OFF: begin
          if (tick) begin
            state_q <= ST_BLINK_ON;
            ledr_q  <= pattern_d;
          end else begin
            ledr_q  <= '0;
          end
        end
        ST_CHASE: begin
          if (tick) ledr_q <= {ledr_q[NLED-2:0], ledr_q[NLED-1]};
        end
        default: begin
          state_q <= ST_OFF;
          ledr_q  <= '0;
        end
      endcase
    end
  end

  // One debouncer per switch bit.
  generate
    for (genvar gi = 0; gi < NSW; gi++) begin : g_deb
      sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .sw_i    (sw[gi]),
        .deb_o   (sw_deb[gi])
      );
    end
  endgenerate

  assign readdata = readdata_q;
  assign ledr     = ledr_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl (NLED=10, NSW=10, DEB_CYCLES=8).
module tb_led_seq_ctrl;

  localparam int NLED = 10;
  localparam int NSW  = 10;

  logic            clk;
  logic            reset_n;
  logic [1:0]      address;
  logic            write;
  logic [31:0]     writedata;
  logic            read;
  logic [31:0]     readdata;
  logic [NSW-1:0]  sw;
  logic [NLED-1:0] ledr;

  int tests_run    = 0;
  int tests_failed = 0;

  led_seq_ctrl #(.NLED(NLED), .NSW(NSW), .DEB_CYCLES(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .read      (read),
    .readdata  (readdata),
    .sw        (sw),
    .ledr      (ledr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    step();
    write = 1'b0;
    $display("[TB] write addr=%0d data=0x%08h", a, d);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    step();
    read = 1'b0;
    d = readdata;
    $display("[TB] read  addr=%0d data=0x%08h", a, d);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    tests_run++;
    if (ledr !== 10'h000) begin tests_failed++; $display("FAIL reset_ledr got=0x%03h exp=0x000", ledr); end
    bus_read(2'd0, rd);
    tests_run++;
    if (rd !== 32'd0) begin tests_failed++; $display("FAIL reset_ctrl got=0x%08h exp=0x00000000", rd); end
    bus_read(2'd1, rd);
    tests_run++;
    if (rd !== 32'd0) begin tests_failed++; $display("FAIL reset_pattern got=0x%08h exp=0x00000000", rd); end
    bus_read(2'd2, rd);
    tests_run++;
    if (rd !== 32'd25000000) begin tests_failed++; $display("FAIL reset_period got=%0d exp=25000000", rd); end
    bus_read(2'd3, rd);
    tests_run++;
    if (rd !== 32'd0) begin tests_failed++; $display("FAIL reset_swstat got=0x%08h exp=0x00000000", rd); end
  endtask

  task automatic test_direct();
    logic [31:0] rd;
    bus_write(2'd1, 32'h0000_02A5);
    tests_run++;
    if (ledr !== 10'h000) begin tests_failed++; $display("FAIL direct_off_before_ctrl got=0x%03h exp=0x000", ledr); end
    bus_write(2'd0, 32'h0000_0004);
    tests_run++;
    if (ledr !== 10'h2A5) begin tests_failed++; $display("FAIL direct_ledr got=0x%03h exp=0x2a5", ledr); end
    bus_read(2'd1, rd);
    tests_run++;
    if (rd !== 32'h0000_02A5) begin tests_failed++; $display("FAIL direct_readback got=0x%08h exp=0x000002a5", rd); end
    bus_write(2'd1, 32'h0000_0155);
    tests_run++;
    if (ledr !== 10'h155) begin tests_failed++; $display("FAIL direct_track got=0x%03h exp=0x155", ledr); end
    bus_write(2'd0, 32'h0000_0007);
    tests_run++;
    if (ledr !== 10'h155) begin tests_failed++; $display("FAIL mode3_direct got=0x%03h exp=0x155", ledr); end
  endtask

  task automatic test_rw_same();
    logic [31:0] rd;
    address = 2'd0; writedata = 32'h0000_0004; write = 1'b1; read = 1'b1;
    step();
    write = 1'b0; read = 1'b0;
    $display("[TB] write+read addr=0 data=0x00000004 rdata=0x%08h", readdata);
    tests_run++;
    if (readdata !== 32'h0000_0007) begin tests_failed++; $display("FAIL rw_same_prewrite got=0x%08h exp=0x00000007", readdata); end
    bus_read(2'd0, rd);
    tests_run++;
    if (rd !== 32'h0000_0004) begin tests_failed++; $display("FAIL rw_same_postwrite got=0x%08h exp=0x00000004", rd); end
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, rd);
    tests_run++;
    if (rd !== 32'd0) begin tests_failed++; $display("FAIL swstat_readonly got=0x%08h exp=0x00000000", rd); end
    bus_write(2'd1, 32'hFFFF_F155);
    bus_read(2'd1, rd);
    tests_run++;
    if (rd !== 32'h0000_0155) begin tests_failed++; $display("FAIL pattern_zero_fill got=0x%08h exp=0x00000155", rd); end
  endtask

  task automatic test_blink();
    logic [NLED-1:0] exp;
    bus_write(2'd2, 32'd4);
    bus_write(2'd1, 32'h0000_03FF);
    bus_write(2'd0, 32'h0000_0005);
    for (int i = 0; i < 16; i++) begin
      exp = (((i / 4) % 2) == 0) ? 10'h3FF : 10'h000;
      tests_run++;
      if (ledr !== exp) begin tests_failed++; $display("FAIL blink cycle=%0d got=0x%03h exp=0x%03h", i, ledr, exp); end
      step();
    end
  endtask

  task automatic test_chase();
    logic [NLED-1:0] exp;
    bus_write(2'd2, 32'd1);
    bus_write(2'd0, 32'h0000_0006);
    for (int i = 0; i < 12; i++) begin
      exp = NLED'(1) << (i % NLED);
      tests_run++;
      if (ledr !== exp) begin tests_failed++; $display("FAIL chase cycle=%0d got=0x%03h exp=0x%03h", i, ledr, exp); end
      step();
    end
  endtask

  task automatic test_period0();
    logic [NLED-1:0] exp;
    bus_write(2'd0, 32'h0000_0005);
    bus_write(2'd2, 32'd0);
    for (int i = 0; i < 8; i++) begin
      exp = ((i % 2) == 0) ? 10'h3FF : 10'h000;
      tests_run++;
      if (ledr !== exp) begin tests_failed++; $display("FAIL period0 cycle=%0d got=0x%03h exp=0x%03h", i, ledr, exp); end
      step();
    end
  endtask

  task automatic test_disable();
    bus_write(2'd0, 32'h0000_0001);
    tests_run++;
    if (ledr !== 10'h000) begin tests_failed++; $display("FAIL disable got=0x%03h exp=0x000", ledr); end
    step(); step(); step();
    tests_run++;
    if (ledr !== 10'h000) begin tests_failed++; $display("FAIL disable_hold got=0x%03h exp=0x000", ledr); end
  endtask

  task automatic test_debounce();
    logic expb;
    address = 2'd3; read = 1'b1;
    step();
    sw[0] = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k == 7) sw[0] = 1'b0;
      if (k == 8) sw[0] = 1'b1;
      // readdata after edge k shows the debounced bit as it was after edge k-1
      expb = (k >= 19);
      tests_run++;
      if (readdata[0] !== expb) begin tests_failed++; $display("FAIL debounce edge=%0d got=%0b exp=%0b", k, readdata[0], expb); end
    end
    read = 1'b0;
    $display("[TB] debounce sequence done swstat=0x%08h", readdata);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bus_write(2'd2, 32'd1);
    bus_read(2'd2, rd);
    tests_run++;
    if (rd !== 32'd1) begin tests_failed++; $display("FAIL period_readback got=%0d exp=1", rd); end
    bus_write(2'd0, 32'h0000_0006);
    step(); step(); step(); step();
    tests_run++;
    if (ledr !== 10'h010) begin tests_failed++; $display("FAIL midreset_pre got=0x%03h exp=0x010", ledr); end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (ledr !== 10'h000) begin tests_failed++; $display("FAIL midreset_async_ledr got=0x%03h exp=0x000", ledr); end
    tests_run++;
    if (readdata !== 32'd0) begin tests_failed++; $display("FAIL midreset_async_rdata got=0x%08h exp=0x00000000", readdata); end
    step(); step();
    reset_n = 1'b1;
    step(); step();
    tests_run++;
    if (ledr !== 10'h000) begin tests_failed++; $display("FAIL postreset_ledr got=0x%03h exp=0x000", ledr); end
    bus_read(2'd0, rd);
    tests_run++;
    if (rd !== 32'd0) begin tests_failed++; $display("FAIL postreset_ctrl got=0x%08h exp=0x00000000", rd); end
    bus_read(2'd2, rd);
    tests_run++;
    if (rd !== 32'd25000000) begin tests_failed++; $display("FAIL postreset_period got=%0d exp=25000000", rd); end
    bus_read(2'd3, rd);
    tests_run++;
    if (rd !== 32'd0) begin tests_failed++; $display("FAIL postreset_swstat got=0x%08h exp=0x00000000", rd); end
  endtask

  initial begin
    reset_n   = 1'b0;
    address   = 2'd0;
    write     = 1'b0;
    writedata = 32'd0;
    read      = 1'b0;
    sw        = '0;
    step(); step(); step();
    reset_n = 1'b1;
    step();
    test_reset();
    test_direct();
    test_rw_same();
    test_blink();
    test_chase();
    test_period0();
    test_disable();
    test_debounce();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
